// File: rtl/single_port_ram_sync.sv
// rtl/single_port_ram_sync.sv - synchronous single-port RAM with clear sequencer on a shared bus
// Clears every word after reset, then serves registered one-cycle reads and zero-latency writes.
module single_port_ram_sync #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  rd_valid,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH:0]   r_clr_cnt;
  logic [ADDR_WIDTH:0]   w_next_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_err;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_rd_req;
  logic                  w_collide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_clr_cnt  <= w_next_cnt;
      r_rd_valid <= w_rd_req;
      r_err      <= w_collide;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clr_cnt;
    w_mem_we     = 1'b0;
    w_mem_addr   = addr;
    w_mem_wdata  = data;
    w_rd_req     = 1'b0;
    w_collide    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // Host requests are ignored; the counter stops once the FSM leaves CLEAR.
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_cnt[ADDR_WIDTH-1:0];
        w_mem_wdata = CLEAR_VALUE;
        w_next_cnt  = r_clr_cnt + CNT_ONE;
        if (r_clr_cnt == CNT_LAST) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_mem_we  = we & ~re;
        w_rd_req  = re & ~we;
        w_collide = re & we;
      end
      default: begin
        w_next_state = ST_CLEAR;
      end
    endcase
  end

  // Storage has no reset; clocks seen while rst_n is low must not clear word 0.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst_n) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_req) begin
      r_rd_data <= r_mem[addr];
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

  // A host write during a read-valid cycle wins the bus; the read word is dropped.
  assign data = (r_rd_valid && !we) ? r_rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_ram_sync.sv
// tb/tb_single_port_ram_sync.sv - directed self-checking bench for single_port_ram_sync
// The bus has pull-ups, so an undriven data bus reads as all ones.
module tb_single_port_ram_sync;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [DW-1:0] HIZ = {DW{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          re;
  logic          we;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;
  logic          ready;
  logic          rd_valid;
  logic          err;
  logic          r_tb_drive;
  logic [DW-1:0] r_tb_wdata;

  int n_checks;
  int n_errors;

  single_port_ram_sync #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .re       (re),
    .we       (we),
    .addr     (addr),
    .data     (data),
    .ready    (ready),
    .rd_valid (rd_valid),
    .err      (err)
  );

  assign data = r_tb_drive ? r_tb_wdata : {DW{1'bz}};

  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (data[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    re         = 1'b0;
    we         = 1'b0;
    r_tb_drive = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    re         = 1'b0;
    we         = 1'b1;
    addr       = a;
    r_tb_drive = 1'b1;
    r_tb_wdata = d;
    tick();
    idle_bus();
  endtask

  // Back-to-back reads of addresses 0..7 checked against exp[].
  task automatic read_sweep(input string tag, input logic [DW-1:0] exp [8]);
    for (int i = 0; i < 8; i++) begin
      re   = 1'b1;
      we   = 1'b0;
      addr = AW'(i);
      tick();
      check($sformatf("%s_vld%0d", tag, i), {31'd0, rd_valid}, 32'd1);
      check($sformatf("%s_dat%0d", tag, i), {16'd0, data}, {16'd0, exp[i]});
    end
    re = 1'b0;
    tick();
    check({tag, "_vld_end"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_hiz_end"}, {16'd0, data}, {16'd0, HIZ});
  endtask

  // Counts the clear edges after rst_n release; ready must rise on exactly the 8th.
  task automatic clear_wait(input string tag);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("%s_rdy%0d", tag, k), {31'd0, ready}, (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("%s_vld%0d", tag, k), {31'd0, rd_valid}, 32'd0);
      check($sformatf("%s_err%0d", tag, k), {31'd0, err}, 32'd0);
      if (k == 3) begin
        idle_bus();
      end
    end
  endtask

  logic [DW-1:0] zeros [8];
  logic [DW-1:0] sweep [8];
  logic [DW-1:0] model [8];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    addr       = '0;
    r_tb_wdata = '0;
    idle_bus();
    for (int i = 0; i < 8; i++) begin
      zeros[i] = 16'h0000;
      sweep[i] = 16'h1000 + 16'(i);
    end

    repeat (2) tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdvld", {31'd0, rd_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hiz", {16'd0, data}, {16'd0, HIZ});

    // Release mid-cycle; host tries a write and a collision while still clearing.
    #3 rst_n = 1'b1;
    we = 1'b1;
    re = 1'b0;
    addr = 3'd1;
    r_tb_drive = 1'b1;
    r_tb_wdata = 16'h1234;
    clear_wait("clr");
    read_sweep("clr_rd", zeros);

    for (int i = 0; i < 8; i++) begin
      write_word(AW'(i), sweep[i]);
    end
    read_sweep("sweep", sweep);
    model = sweep;

    write_word(3'd5, 16'hBEEF);
    model[5] = 16'hBEEF;
    re = 1'b1;
    addr = 3'd5;
    tick();
    check("raw_vld", {31'd0, rd_valid}, 32'd1);
    check("raw_dat", {16'd0, data}, 32'h0000_BEEF);
    re = 1'b0;
    tick();

    re = 1'b1;
    we = 1'b1;
    addr = 3'd2;
    r_tb_drive = 1'b1;
    r_tb_wdata = 16'hFFFF;
    tick();
    idle_bus();
    check("col_err", {31'd0, err}, 32'd1);
    check("col_vld", {31'd0, rd_valid}, 32'd0);
    check("col_hiz", {16'd0, data}, {16'd0, HIZ});
    tick();
    check("col_err_pulse", {31'd0, err}, 32'd0);
    re = 1'b1;
    addr = 3'd2;
    tick();
    check("col_keep_vld", {31'd0, rd_valid}, 32'd1);
    check("col_keep_dat", {16'd0, data}, {16'd0, model[2]});

    // Host write in the read-valid cycle takes the bus from the block.
    addr = 3'd3;
    tick();
    check("wal_rd_dat", {16'd0, data}, {16'd0, model[3]});
    re = 1'b0;
    we = 1'b1;
    addr = 3'd4;
    r_tb_drive = 1'b1;
    r_tb_wdata = 16'h5555;
    #1;
    check("wal_vld", {31'd0, rd_valid}, 32'd1);
    check("wal_bus", {16'd0, data}, 32'h0000_5555);
    tick();
    idle_bus();
    model[4] = 16'h5555;
    read_sweep("post", model);

    // Asynchronous reset while a read is presented on the bus.
    re = 1'b1;
    addr = 3'd7;
    tick();
    check("pre_rst_vld", {31'd0, rd_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_vld", {31'd0, rd_valid}, 32'd0);
    check("arst_hiz", {16'd0, data}, {16'd0, HIZ});
    idle_bus();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("mid_clr_ready", {31'd0, ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    re = 1'b1;
    addr = 3'd6;
    clear_wait("reclr");
    read_sweep("reclr_rd", zeros);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
